// File: rtl/syn_stat_counter_if.sv
// syn_stat_counter_if: status/readout bundle between the CPU side (master) and the statistics counter (slave).
// Signals: en, clr, halt, is_jump, is_branch, branched, sel[1:0] toward the counter;
// cnt_data[CNT_BIT-1:0], halted, overflow back from it.
interface syn_stat_counter_if #(parameter int CNT_BIT = 32);
  logic en;
  logic clr;
  logic halt;
  logic is_jump;
  logic is_branch;
  logic branched;
  logic [1:0] sel;
  logic [CNT_BIT-1:0] cnt_data;
  logic halted;
  logic overflow;
  modport master (
    output en, clr, halt, is_jump, is_branch, branched, sel,
    input  cnt_data, halted, overflow
  );
  modport slave (
    input  en, clr, halt, is_jump, is_branch, branched, sel,
    output cnt_data, halted, overflow
  );
endinterface

// File: rtl/syn_stat_counter.sv
// syn_stat_counter: retired-cycle/jump/branch/taken statistics with halt freeze, registered readout mux and sticky overflow.
// Ports: clk, rst (sync, active-high), bus (syn_stat_counter_if.slave: en, clr, halt, is_jump, is_branch,
// branched, sel in; cnt_data, halted, overflow out). Parameter CNT_BIT (4..32) sets counter and readout width.
// Build option: define STAT_SAT_EN to make counters saturate instead of wrapping.
module syn_stat_counter #(
  parameter int CNT_BIT = 32
) (
  input logic clk,
  input logic rst,
  syn_stat_counter_if.slave bus
);
  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;
  logic [0:0] state;
  logic [CNT_BIT-1:0] cnt [4];
  logic [CNT_BIT-1:0] nxt [4];
  logic [CNT_BIT-1:0] data;
  logic [3:0] inc;
  logic [3:0] full;
  logic ovf;
  logic retire;
  // the halting instruction itself is never counted
  assign retire = state == RUN && bus.en && !bus.halt && !bus.clr;
  // index order matches sel: cycles, jumps, branches, taken
  assign inc = {retire & bus.is_branch & bus.branched, retire & bus.is_branch, retire & bus.is_jump, retire};
  always_comb begin
    full = '0;
    nxt = '{default: '0};
    for (int i = 0; i < 4; i++) begin
      full[i] = &cnt[i];
`ifdef STAT_SAT_EN
      nxt[i] = full[i] ? cnt[i] : cnt[i] + 1'b1;
`else
      nxt[i] = cnt[i] + 1'b1;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      state <= RUN;
      data <= '0;
      ovf <= 1'b0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      data <= cnt[bus.sel];
      ovf <= ovf | |(inc & full);
      if (state == RUN && bus.halt) state <= HALTED;
      for (int i = 0; i < 4; i++) if (inc[i]) cnt[i] <= nxt[i];
    end
  end
  assign bus.cnt_data = data;
  assign bus.halted = state == HALTED;
  assign bus.overflow = ovf;
endmodule
